// File: rtl/cell_sweep_checker.sv
// Exhaustive truth-table sweeper for a single-output combinational cell: drives every input
// vector, samples the cell after a settle window and checks it against an expected table.
module cell_sweep_checker #(
  parameter int unsigned            N_IN       = 3,
  parameter int unsigned            SETTLE_CYC = 4,
  parameter logic [(2**N_IN)-1:0]   EXP_TT     = 8'h1F
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_in,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            sample_valid,
  output logic [N_IN-1:0] sample_idx,
  output logic            sample_val
);

  localparam int unsigned    CntW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0] LastVec = {N_IN{1'b1}};

  typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N_IN:0]     err_q, err_d;
  logic              ffv_q, ffv_d;
  logic [N_IN-1:0]   ffi_q, ffi_d;
  logic              sv_q, sv_d;
  logic [N_IN-1:0]   sidx_q, sidx_d;
  logic              sval_q, sval_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    sv_d    = 1'b0;
    sidx_d  = sidx_q;
    sval_d  = sval_q;
    unique case (state_q)
      StIdle, StDone: begin
        // first_fail_idx and the sample stream deliberately survive a restart
        if (start) begin
          state_d = StSettle;
          cnt_d   = '0;
          vec_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = '0;
          ffv_d   = 1'b0;
        end
      end
      StSettle: begin
        if (cnt_q == LastCnt) begin
          sv_d   = 1'b1;
          sidx_d = vec_q;
          sval_d = dut_in;
          if (dut_in != EXP_TT[vec_q]) begin
            err_d = err_q + (N_IN + 1)'(1);
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = vec_q;
            end
          end
          if (vec_q == LastVec) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_d = vec_q + N_IN'(1);
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
      sv_q    <= 1'b0;
      sidx_q  <= '0;
      sval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
      sv_q    <= sv_d;
      sidx_q  <= sidx_d;
      sval_q  <= sval_d;
    end
  end

  assign vec_out          = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = done_q & ~|err_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;
  assign sample_valid     = sv_q;
  assign sample_idx       = sidx_q;
  assign sample_val       = sval_q;

endmodule

// File: tb/tb_cell_sweep_checker.sv
// Directed bench for cell_sweep_checker: OAI21 default build plus an N_IN=1 inverter build.
module tb_cell_sweep_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       dut_in;
  logic [1:0] mode;  // 0: OAI21 model, 1: tied high, 2: tied low
  logic [2:0] vec_out;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic       first_fail_valid;
  logic [2:0] first_fail_idx;
  logic       sample_valid;
  logic [2:0] sample_idx;
  logic       sample_val;

  logic       start1, dut_in1;
  logic [0:0] vec_out1;
  logic       busy1, done1, pass1;
  logic [1:0] err_count1;
  logic       ffv1;
  logic [0:0] ffi1;
  logic       sv1;
  logic [0:0] sidx1;
  logic       sval1;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    dut_in = 1'b0;
    case (mode)
      2'd0:    dut_in = ~(vec_out[2] & (vec_out[1] | vec_out[0]));
      2'd1:    dut_in = 1'b1;
      default: dut_in = 1'b0;
    endcase
  end

  assign dut_in1 = ~vec_out1[0];

  cell_sweep_checker u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .dut_in           (dut_in),
    .vec_out          (vec_out),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_idx   (first_fail_idx),
    .sample_valid     (sample_valid),
    .sample_idx       (sample_idx),
    .sample_val       (sample_val)
  );

  cell_sweep_checker #(
    .N_IN       (1),
    .SETTLE_CYC (1),
    .EXP_TT     (2'b01)
  ) u_dut1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start1),
    .dut_in           (dut_in1),
    .vec_out          (vec_out1),
    .busy             (busy1),
    .done             (done1),
    .pass             (pass1),
    .err_count        (err_count1),
    .first_fail_valid (ffv1),
    .first_fail_idx   (ffi1),
    .sample_valid     (sv1),
    .sample_idx       (sidx1),
    .sample_val       (sval1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " vec_out"}, 32'(vec_out), 0);
    check_eq({tag, " busy"}, 32'(busy), 0);
    check_eq({tag, " done"}, 32'(done), 0);
    check_eq({tag, " pass"}, 32'(pass), 0);
    check_eq({tag, " err_count"}, 32'(err_count), 0);
    check_eq({tag, " ffv"}, 32'(first_fail_valid), 0);
    check_eq({tag, " ffi"}, 32'(first_fail_idx), 0);
    check_eq({tag, " sample_valid"}, 32'(sample_valid), 0);
    check_eq({tag, " sample_idx"}, 32'(sample_idx), 0);
    check_eq({tag, " sample_val"}, 32'(sample_val), 0);
  endtask

  // Runs one sweep on u_dut; i counts edges after the start edge (i=0 is the start edge).
  task automatic sweep(input string tag, input int restart_at, output int done_cyc,
                       output logic [7:0] vals);
    int n_strobe;
    int last_strobe;
    done_cyc    = -1;
    n_strobe    = 0;
    last_strobe = -1;
    vals        = '0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start = (i == restart_at);
      if (i == 0) begin
        check_eq({tag, " busy after start"}, 32'(busy), 1);
        check_eq({tag, " done after start"}, 32'(done), 0);
        check_eq({tag, " pass after start"}, 32'(pass), 0);
      end
      if (sample_valid) begin
        check_eq({tag, " strobe idx"}, 32'(sample_idx), n_strobe);
        if (n_strobe < 8) vals[n_strobe] = sample_val;
        n_strobe++;
        last_strobe = i;
      end
      if (done) begin
        done_cyc = i;
        break;
      end
    end
    start = 1'b0;
    check_eq({tag, " done cycle"}, 32'(done_cyc), 32);
    check_eq({tag, " strobes"}, 32'(n_strobe), 8);
    check_eq({tag, " last strobe with done"}, 32'(last_strobe), 32);
    check_eq({tag, " busy at done"}, 32'(busy), 0);
    check_eq({tag, " vec_out held"}, 32'(vec_out), 7);
  endtask

  initial begin
    int          dc;
    logic [7:0]  vals;
    logic [1:0]  vals1;
    int          n1;
    bit          seen;

    rst_n  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    mode   = 2'd0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle busy", 32'(busy), 0);

    // OAI21 reference cell
    sweep("oai21", -1, dc, vals);
    check_eq("oai21 vals", 32'(vals), 32'h1F);
    check_eq("oai21 err", 32'(err_count), 0);
    check_eq("oai21 pass", 32'(pass), 1);
    check_eq("oai21 ffv", 32'(first_fail_valid), 0);

    // Restart from DONE with output stuck high
    mode = 2'd1;
    sweep("tied1", -1, dc, vals);
    check_eq("tied1 vals", 32'(vals), 32'hFF);
    check_eq("tied1 err", 32'(err_count), 3);
    check_eq("tied1 ffv", 32'(first_fail_valid), 1);
    check_eq("tied1 ffi", 32'(first_fail_idx), 5);
    check_eq("tied1 pass", 32'(pass), 0);

    mode = 2'd2;
    sweep("tied0", -1, dc, vals);
    check_eq("tied0 vals", 32'(vals), 32'h00);
    check_eq("tied0 err", 32'(err_count), 5);
    check_eq("tied0 ffi", 32'(first_fail_idx), 0);
    check_eq("tied0 pass", 32'(pass), 0);

    // Reset in the middle of vector 3 with mismatches already accumulated
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (vec_out == 3'd3) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("midrst reached vec3", 32'(seen), 1);
    check_eq("midrst err before", 32'(err_count), 3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("midrst no resume busy", 32'(busy), 0);
    check_eq("midrst no resume done", 32'(done), 0);
    mode = 2'd0;
    sweep("after rst", -1, dc, vals);
    check_eq("after rst vals", 32'(vals), 32'h1F);
    check_eq("after rst pass", 32'(pass), 1);

    // Extra start pulse while busy must be ignored
    sweep("restart busy", 10, dc, vals);
    check_eq("restart busy pass", 32'(pass), 1);
    repeat (3) @(negedge clk);
    check_eq("done sticky", 32'(done), 1);

    // N_IN=1, SETTLE_CYC=1 inverter
    n1    = 0;
    dc    = -1;
    vals1 = '0;
    @(negedge clk);
    start1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (i >= 1 && i <= 2) check_eq("inv strobe continuous", 32'(sv1), 1);
      if (sv1) begin
        check_eq("inv strobe idx", 32'(sidx1), n1);
        if (n1 < 2) vals1[n1] = sval1;
        n1++;
      end
      if (done1) begin
        dc = i;
        break;
      end
    end
    check_eq("inv done cycle", 32'(dc), 2);
    check_eq("inv strobes", 32'(n1), 2);
    check_eq("inv vals", 32'(vals1), 32'h1);
    check_eq("inv err", 32'(err_count1), 0);
    check_eq("inv pass", 32'(pass1), 1);
    @(negedge clk);
    check_eq("inv strobe ends", 32'(sv1), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cell_sweep_checker.md
Name: cell_sweep_checker

Overview:
- Synthesisable, self-checking exhaustive truth-table sweeper for single-output combinational standard cells (OAI/AOI/NAND/NOR family, any drive strength).
- Drives every input vector 0..2^N_IN-1 onto the cell under test, waits a programmable settle time and samples the cell output.
- Compares each sample against a parameterised expected truth table and reports mismatch count, first failing vector and pass/fail.
- Generalises the fixed 3-input, fixed-delay display-only bench style to arbitrary input count, with automatic checking and a per-sample debug stream.

Parameters:
- N_IN, 3, number of cell inputs (1..8); vec_out bit N_IN-1 maps to the first-listed cell input (e.g. A), bit 0 to the last (e.g. B2).
- SETTLE_CYC, 4, clock cycles each vector is held before sampling (>=1).
- EXP_TT, 8'h1F, expected-output truth table, width 2^N_IN; bit k = expected output for vector k. The default is OAI21: ZN = ~(A & (B1|B2)).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a sweep when idle
- dut_in  in  1  output of the cell under test
- vec_out  out  N_IN  input vector driven to the cell under test
- busy  out  1  high while a sweep is in progress
- done  out  1  sticky; high after a sweep completes until the next accepted start
- pass  out  1  done && (err_count == 0)
- err_count  out  N_IN+1  mismatches in the current/last sweep (max 2^N_IN, no saturation needed)
- first_fail_valid  out  1  at least one mismatch seen in this sweep
- first_fail_idx  out  N_IN  vector index of the first mismatch
- sample_valid  out  1  one-cycle strobe per sampled vector
- sample_idx  out  N_IN  vector index for the current strobe
- sample_val  out  1  sampled dut_in value for the current strobe

Behaviour:
- Reset (async, rst_n=0): state IDLE. vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_idx=0, sample_valid=0, sample_idx=0, sample_val=0, settle counter=0.
- States: IDLE, SETTLE, DONE.
- IDLE/DONE + start=1 at edge T:
  - at T: vec_out<=0, busy<=1, done<=0, err_count<=0, first_fail_valid<=0, counter<=0; go to SETTLE.
  - first_fail_idx and the sample outputs are not cleared by start.
- SETTLE: counter increments each edge while counter < SETTLE_CYC-1. At the edge where counter == SETTLE_CYC-1, dut_in is sampled and registered as the check for vector k = vec_out:
  - sample_valid<=1, sample_idx<=k, sample_val<=dut_in (strobe lasts exactly one cycle).
  - if dut_in != EXP_TT[k]: err_count<=err_count+1; if first_fail_valid==0, then first_fail_idx<=k and first_fail_valid<=1.
  - if k < 2^N_IN-1: vec_out<=k+1, counter<=0, stay in SETTLE.
  - if k == 2^N_IN-1: busy<=0, done<=1, go to DONE; vec_out holds its last value.
- Timing:
  - each vector is held exactly SETTLE_CYC cycles.
  - the sweep occupies 2^N_IN*SETTLE_CYC cycles from the start edge to the edge raising done.
  - the last sample strobe and done assert on the same edge.
- pass is combinational: done & ~|err_count.
- start while busy: ignored; the sweep continues unaffected.
- start in DONE: restarts a new sweep, clearing done and pass immediately.
- SETTLE_CYC=1: a new vector and a sample strobe occur on every cycle, and sample_valid stays high for the whole sweep.
- Reset mid-sweep: all outputs return to reset values immediately. No partial result is retained, and no sweep resumes on release.
- err_count width N_IN+1 holds an all-vectors-fail result (2^N_IN) without overflow.

Test Plan:
- N_IN=3, SETTLE_CYC=4, EXP_TT=8'h1F, dut_in from a behavioural OAI21 model; pulse start -> 8 strobes with sample_val 1,1,1,1,1,0,0,0; done after 32 cycles; err_count=0, pass=1, first_fail_valid=0.
- Same setup, dut_in tied 1 -> mismatches at idx 5,6,7; err_count=3; first_fail_idx=5; pass=0.
- Same setup, dut_in tied 0 -> err_count=5; first_fail_idx=0; pass=0.
- Assert rst_n=0 during vector 3 -> all outputs at reset values immediately. After release, start gives a clean full sweep with pass=1.
- Pulse start again during a sweep -> ignored; done still at cycle 32. Start in DONE -> done drops next edge and a new sweep runs.
- N_IN=1, SETTLE_CYC=1, EXP_TT=2'b01, dut_in=~vec_out[0] (inverter) -> 2 consecutive strobes; done after 2 cycles; pass=1.
